imem_prog_fetch: RTL and testbench
==================================

Name: imem_prog_fetch

Overview:
- Parametrised instruction memory that succeeds the fixed 1000-word combinational-read instruction store.
- After reset it zero-clears itself word by word, then accepts a program load over a write port. It then serves CPU fetches with a registered, 1-cycle read and fault reporting.
- Sits between the fetch stage (PC in, instruction out) and the testbench/boot loader (program port).

Parameters:
- DEPTH, 1024, number of words; any value >= 2, not necessarily a power of 2.
- DATA_W, 32, instruction word width in bits.
- NOP_WORD, 32'h0000_0013, word returned on a faulted fetch (RISC-V addi x0,x0,0).
- AW (localparam), $clog2(DEPTH), word-index width.

Ports:
- SYS_clk  in  1  single clock; all state changes on its rising edge.
- SYS_reset  in  1  synchronous, active-high reset.
- prog_we  in  1  program-write strobe (LOAD state only).
- prog_addr  in  32  byte address of program word.
- prog_data  in  DATA_W  program word.
- prog_done  in  1  pulse: loading finished, enter RUN.
- prog_err  out  1  1-cycle pulse: program write rejected.
- fetch_req  in  1  fetch request.
- fetch_pc  in  32  byte address to fetch.
- fetch_ready  out  1  high only in RUN.
- fetch_valid  out  1  fetch result valid, one cycle after the accepted request.
- fetch_instr  out  DATA_W  fetched word.
- fetch_fault  out  2  00 ok, 01 misaligned, 10 out of range.
- mem_state  out  2  00 CLEAR, 01 LOAD, 10 RUN.

Behaviour:
- Reset: state=CLEAR, clear counter=0; prog_err=0, fetch_valid=0, fetch_instr=0, fetch_fault=00, fetch_ready=0. Applies in any state, including mid-CLEAR, which restarts the clear from word 0. Memory contents are not otherwise touched by reset.
- CLEAR:
  - Writes 0 to word[cnt] each cycle and increments cnt.
  - After the cycle that writes word DEPTH-1, goes to LOAD, so CLEAR lasts exactly DEPTH cycles.
  - prog_* and fetch_req are ignored; no prog_err, no fetch_valid.
- LOAD:
  - On prog_we, write prog_data to word[prog_addr>>2] when prog_addr[1:0]==0 and (prog_addr>>2) < DEPTH.
  - Otherwise no write; prog_err=1 on the next cycle.
  - prog_done moves to RUN on the next cycle. If prog_we and prog_done are high in the same cycle, the write is performed first.
  - fetch_req is ignored.
- RUN:
  - fetch_ready=1. prog_we is ignored, with no prog_err. Only SYS_reset leaves RUN.
  - When fetch_req=1, the request is accepted. On the next cycle fetch_valid=1 and fetch_instr/fetch_fault are set:
    - fetch_pc[1:0]!=0 -> fault 01, instr=NOP_WORD.
    - else if (fetch_pc>>2) >= DEPTH -> fault 10, instr=NOP_WORD.
    - else fault 00, instr=word[fetch_pc>>2].
    - Misalignment takes priority over out-of-range.
  - Back-to-back requests give one result per cycle, in order.
  - fetch_req=0 gives fetch_valid=0 next cycle; fetch_instr/fetch_fault hold their last values.
- Width rules: fetch_pc and prog_addr are compared at the full 32 bits before indexing, so no aliasing or wrap-around occurs.
- Read-during-write cannot occur, because writes happen only in CLEAR/LOAD and reads only in RUN.

Optional Feature:
- Macro IMEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed on every write, including CLEAR writes of 0.
  - A RUN fetch with a parity mismatch on an otherwise valid access returns fault 11 and NOP_WORD.
  - Out-of-range and misaligned faults take priority over parity.
- When undefined: no parity storage, and code 11 is never produced.

Test Plan:
- Reset held 1 cycle, then released -> mem_state=00 for exactly DEPTH cycles, then 01. Asserting reset mid-CLEAR at cnt=5 -> CLEAR restarts and again lasts DEPTH cycles.
- LOAD: write 0xDEADBEEF at 0x8 and 0x00500093 at 0x0, pulse prog_done -> in RUN, fetch 0x0 gives instr 0x00500093 fault 00; fetch 0x4 gives 0x00000000 (cleared); fetch 0x8 gives 0xDEADBEEF. Each result appears 1 cycle after its request.
- RUN: fetch_pc=0x6 -> fault 01, instr 0x00000013. fetch_pc=DEPTH*4 -> fault 10, instr 0x00000013. fetch_pc=0xFFFFFFFC -> fault 10, with no aliasing.
- LOAD: prog_we at address 0x3 and at DEPTH*4 -> prog_err pulses, memory unchanged. Same-cycle prog_we(0x4,0x12345678)+prog_done -> in RUN, fetch 0x4 returns 0x12345678.
- Fetch requests during CLEAR/LOAD, or prog_we during RUN -> no fetch_valid, no write, no prog_err. Three consecutive RUN requests -> three consecutive valid cycles, in order.
- With IMEM_PARITY_EN: flip one stored data bit via hierarchical force, then fetch it -> fault 11, instr 0x00000013. A clean word -> fault 00.

Source files
------------

// File: rtl/imem_prog_fetch.sv
// imem_prog_fetch: parametrised instruction memory with a self-clear phase,
// a program-load phase and a registered single-cycle fetch port that
// reports faults.
// The optional per-word even parity is enabled by the macro IMEM_PARITY_EN.
module imem_prog_fetch #(
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0013)
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              prog_we,
  input  logic [31:0]       prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_done,
  output logic              prog_err,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [1:0]        fetch_fault,
  output logic [1:0]        mem_state
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_32 = 32'(DEPTH);

  localparam logic [1:0] S_CLEAR = 2'b00;
  localparam logic [1:0] S_LOAD  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;

  localparam logic [1:0] F_OK     = 2'b00;
  localparam logic [1:0] F_MISAL  = 2'b01;
  localparam logic [1:0] F_RANGE  = 2'b10;
`ifdef IMEM_PARITY_EN
  localparam logic [1:0] F_PARITY = 2'b11;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef IMEM_PARITY_EN
  logic              par_q [DEPTH];
`endif

  logic [1:0]        state_q;
  logic [AW-1:0]     cnt_q;
  logic              prog_err_q;
  logic              fetch_valid_q;
  logic [DATA_W-1:0] fetch_instr_q;
  logic [1:0]        fetch_fault_q;

  logic              prog_ok;
  logic              fetch_misal;
  logic              fetch_in_range;
  logic [AW-1:0]     fetch_idx;
  logic [DATA_W-1:0] rd_word;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data;

  // Range checks use the full 32-bit word index so high address bits never alias.
  assign prog_ok        = (prog_addr[1:0] == 2'b00) && ({2'b00, prog_addr[31:2]} < DEPTH_32);
  assign fetch_misal    = (fetch_pc[1:0] != 2'b00);
  assign fetch_in_range = ({2'b00, fetch_pc[31:2]} < DEPTH_32);
  assign fetch_idx      = fetch_pc[AW+1:2];
  assign rd_word        = mem_q[fetch_idx];

  // Select the single write source: clear sweep in CLEAR, program port in LOAD.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (!SYS_reset) begin
      case (state_q)
        S_CLEAR: begin
          wr_en  = 1'b1;
          wr_idx = cnt_q;
        end
        S_LOAD: begin
          wr_en   = prog_we && prog_ok;
          wr_idx  = prog_addr[AW+1:2];
          wr_data = prog_data;
        end
        default: ;
      endcase
    end
  end

  // Storage array; deliberately not reset, contents change only via writes.
  always_ff @(posedge SYS_clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
`ifdef IMEM_PARITY_EN
      par_q[wr_idx] <= ^wr_data;
`endif
    end
  end

  // Phase sequencing, program-error pulse and the registered fetch result.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q       <= S_CLEAR;
      cnt_q         <= '0;
      prog_err_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      fetch_fault_q <= F_OK;
    end else begin
      prog_err_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_LOAD: begin
          if (prog_we && !prog_ok) prog_err_q <= 1'b1;
          if (prog_done)           state_q    <= S_RUN;
        end
        S_RUN: begin
          if (fetch_req) begin
            fetch_valid_q <= 1'b1;
            if (fetch_misal) begin
              fetch_fault_q <= F_MISAL;
              fetch_instr_q <= NOP_WORD;
            end else if (!fetch_in_range) begin
              fetch_fault_q <= F_RANGE;
              fetch_instr_q <= NOP_WORD;
`ifdef IMEM_PARITY_EN
            end else if ((^rd_word) != par_q[fetch_idx]) begin
              fetch_fault_q <= F_PARITY;
              fetch_instr_q <= NOP_WORD;
`endif
            end else begin
              fetch_fault_q <= F_OK;
              fetch_instr_q <= rd_word;
            end
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign prog_err    = prog_err_q;
  assign fetch_ready = (state_q == S_RUN);
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_fault = fetch_fault_q;
  assign mem_state   = state_q;

endmodule

// File: tb/tb_imem_prog_fetch.sv
// Self-checking bench for imem_prog_fetch (DEPTH=10, non power of two).
// Fetch results are checked through an expectation queue; define
// IMEM_PARITY_EN on both files to exercise the parity path.
module tb_imem_prog_fetch;

  localparam int unsigned DEPTH = 10;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        prog_done;
  logic        prog_err;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [1:0]  fetch_fault;
  logic [1:0]  mem_state;

  imem_prog_fetch #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .SYS_clk     (SYS_clk),
    .SYS_reset   (SYS_reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_done   (prog_done),
    .prog_err    (prog_err),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .mem_state   (mem_state)
  );

  always #5 SYS_clk = ~SYS_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  fault;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  fault;
  } exp_t;

  vec_t        vecs [13];
  exp_t        sb_q [$];
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge and scoreboarded.
  task automatic step();
    exp_t e;
    @(posedge SYS_clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("fetch_valid", 32'(fetch_valid), 32'd1);
      chk("fetch_instr", fetch_instr, e.instr);
      chk("fetch_fault", 32'(fetch_fault), 32'(e.fault));
    end else begin
      chk("no_fetch_valid", 32'(fetch_valid), 32'd0);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input logic [1:0] fault);
    exp_t e;
    e.instr   = instr;
    e.fault   = fault;
    fetch_req = 1'b1;
    fetch_pc  = pc;
    sb_q.push_back(e);
  endtask

  // Counts cycles spent in CLEAR while prog/fetch inputs are being waved at it.
  task automatic count_clear(input string name);
    int unsigned n = 0;
    prog_we   = 1'b1;
    prog_addr = 32'h3;
    prog_data = 32'hFFFF_FFFF;
    prog_done = 1'b1;
    fetch_req = 1'b1;
    fetch_pc  = 32'h0;
    while (mem_state == 2'b00 && n < 100) begin
      step();
      chk("clear_prog_err", 32'(prog_err), 32'd0);
      n++;
    end
    chk(name, n, DEPTH);
    chk("after_clear_state", 32'(mem_state), 32'd1);
    prog_we   = 1'b0;
    prog_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h0000_0000, 32'h0050_0093, 2'b00};
    vecs[1]  = '{32'h0000_0004, 32'h1234_5678, 2'b00};
    vecs[2]  = '{32'h0000_000C, 32'h0000_0000, 2'b00};
    vecs[3]  = '{32'h0000_0024, 32'h0000_0000, 2'b00};
    vecs[4]  = '{32'h0000_0006, NOP,           2'b01};
    vecs[5]  = '{32'h0000_0028, NOP,           2'b10};
    vecs[6]  = '{32'hFFFF_FFFC, NOP,           2'b10};
    vecs[7]  = '{32'h0000_0040, NOP,           2'b10};
    vecs[8]  = '{32'hFFFF_FFFF, NOP,           2'b01};
    vecs[9]  = '{32'h0000_0002, NOP,           2'b01};
    vecs[10] = '{32'h0000_0020, 32'h0000_0000, 2'b00};
    vecs[11] = '{32'h0000_0027, NOP,           2'b01};
    vecs[12] = '{32'h0000_0008, 32'hDEAD_BEEF, 2'b00};

    SYS_reset = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_done = 1'b0;
    fetch_req = 1'b0;
    fetch_pc  = '0;

    step();
    chk("rst_state",   32'(mem_state),   32'd0);
    chk("rst_ready",   32'(fetch_ready), 32'd0);
    chk("rst_instr",   fetch_instr,      32'd0);
    chk("rst_fault",   32'(fetch_fault), 32'd0);
    chk("rst_prog_err", 32'(prog_err),   32'd0);
    SYS_reset = 1'b0;
    count_clear("clear_len");

    // Reset mid-clear at cnt=5 restarts the sweep.
    SYS_reset = 1'b1;
    step();
    SYS_reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("midclear_state", 32'(mem_state), 32'd0);
    SYS_reset = 1'b1;
    step();
    SYS_reset = 1'b0;
    count_clear("clear_len_restart");

    // LOAD: fetches ignored throughout.
    fetch_req = 1'b1;
    fetch_pc  = 32'h0;
    prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'hDEAD_BEEF;
    step(); chk("load_ok_err0", 32'(prog_err), 32'd0);
    prog_addr = 32'h0; prog_data = 32'h0050_0093;
    step(); chk("load_ok_err1", 32'(prog_err), 32'd0);
    chk("load_ready", 32'(fetch_ready), 32'd0);
    prog_addr = 32'h3; prog_data = 32'hBAD0_0001;
    step(); chk("misal_prog_err", 32'(prog_err), 32'd1);
    prog_addr = DEPTH * 4; prog_data = 32'hBAD0_0002;
    step(); chk("range_prog_err", 32'(prog_err), 32'd1);
    prog_we = 1'b0;
    step(); chk("prog_err_pulse", 32'(prog_err), 32'd0);
    prog_we = 1'b1; prog_addr = 32'h40; prog_data = 32'hBAD0_0003;
    step(); chk("alias_prog_err", 32'(prog_err), 32'd1);
    prog_addr = 32'h4; prog_data = 32'h1234_5678; prog_done = 1'b1;
    fetch_req = 1'b0;
    step();
    chk("done_state", 32'(mem_state), 32'd2);
    chk("done_prog_err", 32'(prog_err), 32'd0);
    prog_done = 1'b0;

    // RUN: program writes are ignored silently.
    prog_addr = 32'h8; prog_data = 32'h0;
    step(); chk("run_prog_err", 32'(prog_err), 32'd0);
    prog_addr = 32'h3;
    step(); chk("run_bad_prog_err", 32'(prog_err), 32'd0);
    prog_we = 1'b0;
    chk("run_ready", 32'(fetch_ready), 32'd1);

    // Back-to-back fetches from the vector table.
    for (int i = 0; i < 13; i++) begin
      fetch(vecs[i].pc, vecs[i].instr, vecs[i].fault);
      step();
    end
    fetch_req = 1'b0;
    step();
    chk("hold_instr", fetch_instr, 32'hDEAD_BEEF);
    chk("hold_fault", 32'(fetch_fault), 32'd0);
    fetch(32'h6, NOP, 2'b01);
    step();
    fetch_req = 1'b0;
    step();
    step();
    chk("hold_instr2", fetch_instr, NOP);
    chk("hold_fault2", 32'(fetch_fault), 32'd1);

`ifdef IMEM_PARITY_EN
    force dut.mem_q[3] = 32'h0000_0001;
    fetch(32'hC, NOP, 2'b11);
    step();
    fetch(32'h0, 32'h0050_0093, 2'b00);
    step();
    fetch(32'hFFFF_FFFD, NOP, 2'b01);
    step();
    fetch_req = 1'b0;
    step();
    release dut.mem_q[3];
`endif

    // Reset out of RUN.
    fetch_req = 1'b1;
    fetch_pc  = 32'h0;
    SYS_reset = 1'b1;
    step();
    chk("rerst_state", 32'(mem_state),   32'd0);
    chk("rerst_instr", fetch_instr,      32'd0);
    chk("rerst_fault", 32'(fetch_fault), 32'd0);
    chk("rerst_ready", 32'(fetch_ready), 32'd0);
    SYS_reset = 1'b0;
    fetch_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
